// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit multicycle core: ALU codes, opcode fields,
// branch conditions, PSR bit positions, controller states and the decode bundle.
package cpu_pkg;

   localparam logic [5:0] ALU_AND  = 6'b000001;
   localparam logic [5:0] ALU_OR   = 6'b000010;
   localparam logic [5:0] ALU_XOR  = 6'b000011;
   localparam logic [5:0] ALU_ADD  = 6'b000101;
   localparam logic [5:0] ALU_ADDU = 6'b000110;
   localparam logic [5:0] ALU_SUB  = 6'b001001;
   localparam logic [5:0] ALU_CMP  = 6'b001011;
   localparam logic [5:0] ALU_MOV  = 6'b001101;
   localparam logic [5:0] ALU_LSH  = 6'b100101;
   localparam logic [5:0] ALU_LUI  = 6'b111111;

   localparam logic [3:0] OP_RTYPE = 4'h0;
   localparam logic [3:0] OP_ANDI  = 4'h1;
   localparam logic [3:0] OP_ORI   = 4'h2;
   localparam logic [3:0] OP_XORI  = 4'h3;
   localparam logic [3:0] OP_MEM   = 4'h4;
   localparam logic [3:0] OP_ADDI  = 4'h5;
   localparam logic [3:0] OP_ADDUI = 4'h6;
   localparam logic [3:0] OP_SHIFT = 4'h8;
   localparam logic [3:0] OP_SUBI  = 4'h9;
   localparam logic [3:0] OP_CMPI  = 4'hB;
   localparam logic [3:0] OP_BCOND = 4'hC;
   localparam logic [3:0] OP_MOVI  = 4'hD;
   localparam logic [3:0] OP_LUI   = 4'hF;

   localparam logic [3:0] EXT_LOAD  = 4'h0;
   localparam logic [3:0] EXT_STOR  = 4'h4;
   localparam logic [3:0] EXT_JCOND = 4'hC;
   localparam logic [3:0] EXT_LSH   = 4'h4;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_HI = 4'h4;
   localparam logic [3:0] COND_LS = 4'h5;
   localparam logic [3:0] COND_GT = 4'h6;
   localparam logic [3:0] COND_LE = 4'h7;
   localparam logic [3:0] COND_FS = 4'h8;
   localparam logic [3:0] COND_FC = 4'h9;
   localparam logic [3:0] COND_LO = 4'hA;
   localparam logic [3:0] COND_HS = 4'hB;
   localparam logic [3:0] COND_LT = 4'hC;
   localparam logic [3:0] COND_GE = 4'hD;
   localparam logic [3:0] COND_UC = 4'hE;
   localparam logic [3:0] COND_NV = 4'hF;

   localparam int unsigned PSR_C = 0;
   localparam int unsigned PSR_L = 2;
   localparam int unsigned PSR_F = 5;
   localparam int unsigned PSR_Z = 6;
   localparam int unsigned PSR_N = 7;

   typedef enum logic [2:0] {
      FETCH,
      IR_LOAD,
      DECODE,
      EXEC,
      MEM_WAIT,
      LOAD_WB
   } state_t;

   typedef struct packed {
      logic alu_wr;
      logic cmp;
      logic add_sub;
      logic load;
      logic stor;
      logic bcond;
      logic jcond;
      logic illegal;
   } decode_t;

   // Codes shared by the R-type opext field and the I-type op field.
   function automatic logic is_alu_code(input logic [3:0] code);
      case (code)
         4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h9, 4'hB, 4'hD: is_alu_code = 1'b1;
         default:                                        is_alu_code = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/cond_eval.sv
// Branch condition evaluator: tests a 4-bit condition code against the PSR.
module cond_eval
   import cpu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] psr,
   input  logic [3:0]       cond,
   output logic             cond_ok
);

   logic n, z, f, l, c;
   logic unused_psr;

   assign n = psr[PSR_N];
   assign z = psr[PSR_Z];
   assign f = psr[PSR_F];
   assign l = psr[PSR_L];
   assign c = psr[PSR_C];
   assign unused_psr = ^{psr[WIDTH-1:8], psr[4:3], psr[1]};

   always_comb begin
      cond_ok = 1'b0;
      case (cond)
         COND_EQ: cond_ok = z;
         COND_NE: cond_ok = !z;
         COND_CS: cond_ok = c;
         COND_CC: cond_ok = !c;
         COND_HI: cond_ok = l;
         COND_LS: cond_ok = !l;
         COND_GT: cond_ok = n;
         COND_LE: cond_ok = !n;
         COND_FS: cond_ok = f;
         COND_FC: cond_ok = !f;
         COND_LO: cond_ok = !l && !z;
         COND_HS: cond_ok = l || z;
         COND_LT: cond_ok = !n && !z;
         COND_GE: cond_ok = n || z;
         COND_UC: cond_ok = 1'b1;
         default: cond_ok = 1'b0;
      endcase
   end

endmodule

// File: rtl/control_fsm.sv
// Multicycle instruction controller: sequences fetch/decode/execute/memory steps,
// decodes the IR into ALU controls, owns the PSR and resolves branches.
module control_fsm
   import cpu_pkg::*;
#(
   parameter int WIDTH         = 16,
   parameter int ALU_CONT_BITS = 6
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [WIDTH-1:0]         mem_rdata,
   input  logic [WIDTH-1:0]         alu_flags,
   output logic [ALU_CONT_BITS-1:0] alu_cont,
   output logic [3:0]               rdest,
   output logic [3:0]               rsrc,
   output logic [WIDTH-1:0]         imm,
   output logic                     b_sel,
   output logic                     reg_we,
   output logic                     wb_sel,
   output logic                     mem_we,
   output logic                     addr_sel,
   output logic                     pc_en,
   output logic [1:0]               pc_src,
   output logic [WIDTH-1:0]         pc_disp,
   output logic [WIDTH-1:0]         psr,
   output logic                     illegal
);

   state_t           state, state_next;
   logic [WIDTH-1:0] ir;
   decode_t          dec;
   logic [3:0]       op, ext;
   logic             cond_ok;
   logic             unused_flags;

   assign op      = ir[15:12];
   assign ext     = ir[7:4];
   assign rdest   = ir[11:8];
   assign rsrc    = ir[3:0];
   assign pc_disp = {{(WIDTH-8){ir[7]}}, ir[7:0]};
   assign unused_flags = ^{alu_flags[WIDTH-1:8], alu_flags[4:3], alu_flags[1]};

   cond_eval #(.WIDTH(WIDTH)) u_cond_eval (
      .psr     (psr),
      .cond    (ir[11:8]),
      .cond_ok (cond_ok)
   );

   always_comb begin
      dec      = '0;
      alu_cont = '0;
      b_sel    = 1'b0;
      imm      = '0;
      case (op)
         OP_RTYPE: begin
            if (ir == '0) begin
               dec = '0;
            end else if (is_alu_code(ext)) begin
               alu_cont    = {2'b00, ext};
               dec.alu_wr  = (ext != OP_CMPI);
               dec.cmp     = (ext == OP_CMPI);
               dec.add_sub = (ext == OP_ADDI) || (ext == OP_SUBI);
            end else begin
               dec.illegal = 1'b1;
            end
         end
         OP_ANDI, OP_ORI, OP_XORI: begin
            alu_cont   = {2'b00, op};
            b_sel      = 1'b1;
            imm        = {{(WIDTH-8){1'b0}}, ir[7:0]};
            dec.alu_wr = 1'b1;
         end
         OP_ADDI, OP_ADDUI, OP_SUBI, OP_CMPI, OP_MOVI: begin
            alu_cont    = {2'b00, op};
            b_sel       = 1'b1;
            imm         = {{(WIDTH-8){ir[7]}}, ir[7:0]};
            dec.alu_wr  = (op != OP_CMPI);
            dec.cmp     = (op == OP_CMPI);
            dec.add_sub = (op == OP_ADDI) || (op == OP_SUBI);
         end
         OP_SHIFT: begin
            if (ext == EXT_LSH) begin
               alu_cont   = ALU_LSH;
               dec.alu_wr = 1'b1;
            end else if (ext[3:1] == 3'b000) begin
               alu_cont   = ALU_LSH;
               b_sel      = 1'b1;
               imm        = {{(WIDTH-5){ir[4]}}, ir[4:0]};
               dec.alu_wr = 1'b1;
            end else begin
               dec.illegal = 1'b1;
            end
         end
         OP_LUI: begin
            alu_cont   = ALU_LUI;
            b_sel      = 1'b1;
            imm        = {{(WIDTH-8){1'b0}}, ir[7:0]};
            dec.alu_wr = 1'b1;
         end
         OP_MEM: begin
            case (ext)
               EXT_LOAD:  dec.load    = 1'b1;
               EXT_STOR:  dec.stor    = 1'b1;
               EXT_JCOND: dec.jcond   = 1'b1;
               default:   dec.illegal = 1'b1;
            endcase
         end
         OP_BCOND: dec.bcond = 1'b1;
         default:  dec.illegal = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= FETCH;
         ir    <= '0;
         psr   <= '0;
      end else begin
         state <= state_next;
         if (state == IR_LOAD)
            ir <= mem_rdata;
         if (state == EXEC) begin
            if (dec.add_sub) begin
               psr[PSR_C] <= alu_flags[PSR_C];
               psr[PSR_F] <= alu_flags[PSR_F];
            end
            if (dec.cmp) begin
               psr[PSR_N] <= alu_flags[PSR_N];
               psr[PSR_Z] <= alu_flags[PSR_Z];
               psr[PSR_L] <= alu_flags[PSR_L];
            end
         end
      end
   end

   always_comb begin
      state_next = state;
      reg_we     = 1'b0;
      wb_sel     = 1'b0;
      mem_we     = 1'b0;
      addr_sel   = 1'b0;
      pc_en      = 1'b0;
      pc_src     = 2'b00;
      illegal    = 1'b0;
      case (state)
         FETCH:   state_next = IR_LOAD;
         IR_LOAD: begin
            pc_en      = 1'b1;
            state_next = DECODE;
         end
         DECODE:  state_next = dec.load ? MEM_WAIT : EXEC;
         EXEC: begin
            reg_we   = dec.alu_wr;
            mem_we   = dec.stor;
            addr_sel = dec.stor;
            illegal  = dec.illegal;
            if (dec.bcond) begin
               pc_en  = cond_ok;
               pc_src = 2'b01;
            end else if (dec.jcond) begin
               pc_en  = cond_ok;
               pc_src = 2'b10;
            end
            state_next = FETCH;
         end
         MEM_WAIT: begin
            addr_sel   = 1'b1;
            state_next = LOAD_WB;
         end
         LOAD_WB: begin
            reg_we     = 1'b1;
            wb_sel     = 1'b1;
            state_next = FETCH;
         end
         default: state_next = FETCH;
      endcase
   end

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: per-scenario tasks with hand-computed expectations.
module tb_control_fsm;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] mem_rdata, alu_flags;
   logic [5:0]  alu_cont;
   logic [3:0]  rdest, rsrc;
   logic [15:0] imm, pc_disp, psr;
   logic        b_sel, reg_we, wb_sel, mem_we, addr_sel, pc_en, illegal;
   logic [1:0]  pc_src;

   int total = 0;
   int bad   = 0;

   // Per-cycle enable traces of the most recent instruction, index 0 = FETCH.
   logic [7:0] r_pc_en, r_reg_we, r_mem_we, r_addr_sel, r_wb_sel, r_illegal;
   logic [1:0] r_src1, r_src3;

   control_fsm #(.WIDTH(16), .ALU_CONT_BITS(6)) dut (
      .clk       (clk),
      .reset     (reset),
      .mem_rdata (mem_rdata),
      .alu_flags (alu_flags),
      .alu_cont  (alu_cont),
      .rdest     (rdest),
      .rsrc      (rsrc),
      .imm       (imm),
      .b_sel     (b_sel),
      .reg_we    (reg_we),
      .wb_sel    (wb_sel),
      .mem_we    (mem_we),
      .addr_sel  (addr_sel),
      .pc_en     (pc_en),
      .pc_src    (pc_src),
      .pc_disp   (pc_disp),
      .psr       (psr),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Runs n cycles from FETCH with the instruction on mem_rdata, recording enables.
   task automatic run(input logic [15:0] instr, input logic [15:0] flags, input int n);
      mem_rdata  = instr;
      alu_flags  = flags;
      r_pc_en    = '0;
      r_reg_we   = '0;
      r_mem_we   = '0;
      r_addr_sel = '0;
      r_wb_sel   = '0;
      r_illegal  = '0;
      for (int i = 0; i < n; i++) begin
         r_pc_en[i]    = pc_en;
         r_reg_we[i]   = reg_we;
         r_mem_we[i]   = mem_we;
         r_addr_sel[i] = addr_sel;
         r_wb_sel[i]   = wb_sel;
         r_illegal[i]  = illegal;
         if (i == 1) r_src1 = pc_src;
         if (i == 3) r_src3 = pc_src;
         step();
      end
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      mem_rdata = 16'h0000;
      alu_flags = 16'h0000;
      step();
      step();
      total++; if (psr !== 16'h0000) begin bad++; $display("FAIL reset_psr got=%h exp=0000", psr); end
      total++; if (alu_cont !== 6'b000000) begin bad++; $display("FAIL reset_alu_cont got=%b exp=000000", alu_cont); end
      total++; if (imm !== 16'h0000) begin bad++; $display("FAIL reset_imm got=%h exp=0000", imm); end
      total++; if (pc_src !== 2'b00) begin bad++; $display("FAIL reset_pc_src got=%b exp=00", pc_src); end
      total++;
      if ({pc_en, reg_we, mem_we, addr_sel, wb_sel, illegal} !== 6'b0) begin
         bad++;
         $display("FAIL reset_enables got=%b exp=000000", {pc_en, reg_we, mem_we, addr_sel, wb_sel, illegal});
      end
      reset = 1'b0;
   endtask

   task automatic test_nop();
      run(16'h0000, 16'hFFFF, 4);
      total++; if (r_pc_en[3:0] !== 4'b0010) begin bad++; $display("FAIL nop_pc_en got=%b exp=0010", r_pc_en[3:0]); end
      total++; if (r_src1 !== 2'b00) begin bad++; $display("FAIL nop_pc_src got=%b exp=00", r_src1); end
      total++;
      if ((r_reg_we[3:0] | r_mem_we[3:0] | r_addr_sel[3:0] | r_illegal[3:0]) !== 4'b0000) begin
         bad++;
         $display("FAIL nop_enables got=%b exp=0000", r_reg_we[3:0] | r_mem_we[3:0] | r_addr_sel[3:0] | r_illegal[3:0]);
      end
      total++; if (psr !== 16'h0000) begin bad++; $display("FAIL nop_psr got=%h exp=0000", psr); end
      run(16'h0000, 16'h0000, 4);
      total++; if (r_pc_en[3:0] !== 4'b0010) begin bad++; $display("FAIL nop2_pc_en got=%b exp=0010", r_pc_en[3:0]); end
   endtask

   task automatic test_alu();
      run(16'h53FF, 16'h0021, 4);
      total++; if (alu_cont !== 6'b000101) begin bad++; $display("FAIL addi_alu_cont got=%b exp=000101", alu_cont); end
      total++; if (imm !== 16'hFFFF) begin bad++; $display("FAIL addi_imm got=%h exp=ffff", imm); end
      total++; if (b_sel !== 1'b1) begin bad++; $display("FAIL addi_b_sel got=%b exp=1", b_sel); end
      total++; if (rdest !== 4'h3) begin bad++; $display("FAIL addi_rdest got=%h exp=3", rdest); end
      total++; if (r_reg_we[3:0] !== 4'b1000) begin bad++; $display("FAIL addi_reg_we got=%b exp=1000", r_reg_we[3:0]); end
      total++; if (r_wb_sel[3:0] !== 4'b0000) begin bad++; $display("FAIL addi_wb_sel got=%b exp=0000", r_wb_sel[3:0]); end
      total++; if (psr !== 16'h0021) begin bad++; $display("FAIL addi_psr got=%h exp=0021", psr); end
      run(16'h0152, 16'h0001, 4);
      total++; if (alu_cont !== 6'b000101) begin bad++; $display("FAIL add_alu_cont got=%b exp=000101", alu_cont); end
      total++; if (b_sel !== 1'b0) begin bad++; $display("FAIL add_b_sel got=%b exp=0", b_sel); end
      total++; if (psr !== 16'h0001) begin bad++; $display("FAIL add_psr got=%h exp=0001", psr); end
      run(16'h01B2, 16'h0044, 4);
      total++; if (alu_cont !== 6'b001011) begin bad++; $display("FAIL cmp_alu_cont got=%b exp=001011", alu_cont); end
      total++; if (r_reg_we[3:0] !== 4'b0000) begin bad++; $display("FAIL cmp_reg_we got=%b exp=0000", r_reg_we[3:0]); end
      total++; if (psr !== 16'h0045) begin bad++; $display("FAIL cmp_psr got=%h exp=0045", psr); end
   endtask

   task automatic test_branch();
      run(16'hC004, 16'hFFFF, 4);
      total++; if (r_pc_en[3:0] !== 4'b1010) begin bad++; $display("FAIL beq_pc_en got=%b exp=1010", r_pc_en[3:0]); end
      total++; if (r_src3 !== 2'b01) begin bad++; $display("FAIL beq_pc_src got=%b exp=01", r_src3); end
      total++; if (pc_disp !== 16'h0004) begin bad++; $display("FAIL beq_pc_disp got=%h exp=0004", pc_disp); end
      total++; if (psr !== 16'h0045) begin bad++; $display("FAIL beq_psr got=%h exp=0045", psr); end
      run(16'hC104, 16'h0000, 4);
      total++; if (r_pc_en[3:0] !== 4'b0010) begin bad++; $display("FAIL bne_pc_en got=%b exp=0010", r_pc_en[3:0]); end
      run(16'h4EC3, 16'h0000, 4);
      total++; if (r_pc_en[3:0] !== 4'b1010) begin bad++; $display("FAIL jcond_pc_en got=%b exp=1010", r_pc_en[3:0]); end
      total++; if (r_src3 !== 2'b10) begin bad++; $display("FAIL jcond_pc_src got=%b exp=10", r_src3); end
      total++; if (rsrc !== 4'h3) begin bad++; $display("FAIL jcond_rsrc got=%h exp=3", rsrc); end
      run(16'hB000, 16'h0080, 4);
      total++; if (psr !== 16'h0081) begin bad++; $display("FAIL cmpi_psr got=%h exp=0081", psr); end
      total++; if (r_reg_we[3:0] !== 4'b0000) begin bad++; $display("FAIL cmpi_reg_we got=%b exp=0000", r_reg_we[3:0]); end
      run(16'hC6FE, 16'h0000, 4);
      total++; if (r_pc_en[3:0] !== 4'b1010) begin bad++; $display("FAIL bgt_pc_en got=%b exp=1010", r_pc_en[3:0]); end
      total++; if (pc_disp !== 16'hFFFE) begin bad++; $display("FAIL bgt_pc_disp got=%h exp=fffe", pc_disp); end
      run(16'hCC02, 16'h0000, 4);
      total++; if (r_pc_en[3:0] !== 4'b0010) begin bad++; $display("FAIL blt_pc_en got=%b exp=0010", r_pc_en[3:0]); end
      run(16'hCF00, 16'h0000, 4);
      total++; if (r_pc_en[3:0] !== 4'b0010) begin bad++; $display("FAIL bnever_pc_en got=%b exp=0010", r_pc_en[3:0]); end
   endtask

   task automatic test_imm_forms();
      run(16'h1380, 16'hFFFF, 4);
      total++; if (imm !== 16'h0080) begin bad++; $display("FAIL andi_imm got=%h exp=0080", imm); end
      total++; if (alu_cont !== 6'b000001) begin bad++; $display("FAIL andi_alu_cont got=%b exp=000001", alu_cont); end
      total++; if (psr !== 16'h0081) begin bad++; $display("FAIL andi_psr got=%h exp=0081", psr); end
      run(16'h841F, 16'h0000, 4);
      total++; if (alu_cont !== 6'b100101) begin bad++; $display("FAIL lshi_alu_cont got=%b exp=100101", alu_cont); end
      total++; if ({b_sel, imm} !== {1'b1, 16'hFFFF}) begin bad++; $display("FAIL lshi_imm got=%b/%h exp=1/ffff", b_sel, imm); end
      run(16'h8442, 16'h0000, 4);
      total++; if ({alu_cont, b_sel} !== {6'b100101, 1'b0}) begin bad++; $display("FAIL lsh_ctrl got=%b/%b exp=100101/0", alu_cont, b_sel); end
      run(16'hF2AB, 16'h0000, 4);
      total++; if (alu_cont !== 6'b111111) begin bad++; $display("FAIL lui_alu_cont got=%b exp=111111", alu_cont); end
      total++; if (imm !== 16'h00AB) begin bad++; $display("FAIL lui_imm got=%h exp=00ab", imm); end
      total++; if (r_reg_we[3:0] !== 4'b1000) begin bad++; $display("FAIL lui_reg_we got=%b exp=1000", r_reg_we[3:0]); end
   endtask

   task automatic test_memory();
      run(16'h4502, 16'hFFFF, 5);
      total++; if (r_addr_sel[4:0] !== 5'b01000) begin bad++; $display("FAIL load_addr_sel got=%b exp=01000", r_addr_sel[4:0]); end
      total++; if (r_reg_we[4:0] !== 5'b10000) begin bad++; $display("FAIL load_reg_we got=%b exp=10000", r_reg_we[4:0]); end
      total++; if (r_wb_sel[4:0] !== 5'b10000) begin bad++; $display("FAIL load_wb_sel got=%b exp=10000", r_wb_sel[4:0]); end
      total++; if (r_pc_en[4:0] !== 5'b00010) begin bad++; $display("FAIL load_pc_en got=%b exp=00010", r_pc_en[4:0]); end
      total++; if ({rdest, rsrc} !== 8'h52) begin bad++; $display("FAIL load_regs got=%h exp=52", {rdest, rsrc}); end
      run(16'h0000, 16'h0000, 4);
      total++; if (r_pc_en[3:0] !== 4'b0010) begin bad++; $display("FAIL after_load_pc_en got=%b exp=0010", r_pc_en[3:0]); end
      run(16'h4642, 16'h0000, 4);
      total++; if (r_mem_we[3:0] !== 4'b1000) begin bad++; $display("FAIL stor_mem_we got=%b exp=1000", r_mem_we[3:0]); end
      total++; if (r_addr_sel[3:0] !== 4'b1000) begin bad++; $display("FAIL stor_addr_sel got=%b exp=1000", r_addr_sel[3:0]); end
      total++; if (r_reg_we[3:0] !== 4'b0000) begin bad++; $display("FAIL stor_reg_we got=%b exp=0000", r_reg_we[3:0]); end
   endtask

   task automatic test_illegal();
      run(16'h0007, 16'hFFFF, 4);
      total++; if (r_illegal[3:0] !== 4'b1000) begin bad++; $display("FAIL ill_pulse got=%b exp=1000", r_illegal[3:0]); end
      total++;
      if ((r_reg_we[3:0] | r_mem_we[3:0]) !== 4'b0000) begin
         bad++;
         $display("FAIL ill_writes got=%b exp=0000", r_reg_we[3:0] | r_mem_we[3:0]);
      end
      total++; if (psr !== 16'h0081) begin bad++; $display("FAIL ill_psr got=%h exp=0081", psr); end
      total++; if (r_pc_en[3:0] !== 4'b0010) begin bad++; $display("FAIL ill_pc_en got=%b exp=0010", r_pc_en[3:0]); end
      run(16'h7000, 16'hFFFF, 4);
      total++; if (r_illegal[3:0] !== 4'b1000) begin bad++; $display("FAIL ill_op7 got=%b exp=1000", r_illegal[3:0]); end
      run(16'h4010, 16'hFFFF, 4);
      total++; if (r_illegal[3:0] !== 4'b1000) begin bad++; $display("FAIL ill_memext got=%b exp=1000", r_illegal[3:0]); end
      run(16'h0000, 16'h0000, 4);
      total++; if (r_illegal[3:0] !== 4'b0000) begin bad++; $display("FAIL ill_cleared got=%b exp=0000", r_illegal[3:0]); end
   endtask

   task automatic test_reset_mid();
      mem_rdata = 16'h4502;
      alu_flags = 16'h0000;
      step();
      step();
      step();
      total++; if (addr_sel !== 1'b1) begin bad++; $display("FAIL mid_mem_wait_addr got=%b exp=1", addr_sel); end
      reset = 1'b1;
      #1;
      total++;
      if ({reg_we, addr_sel, pc_en, mem_we, wb_sel} !== 5'b0) begin
         bad++;
         $display("FAIL mid_reset_enables got=%b exp=00000", {reg_we, addr_sel, pc_en, mem_we, wb_sel});
      end
      total++; if ({psr, rdest} !== 20'h0) begin bad++; $display("FAIL mid_reset_state got=%h exp=00000", {psr, rdest}); end
      step();
      total++; if (reg_we !== 1'b0) begin bad++; $display("FAIL mid_reset_hold got=%b exp=0", reg_we); end
      reset = 1'b0;
      run(16'h0000, 16'h0000, 4);
      total++; if (r_pc_en[3:0] !== 4'b0010) begin bad++; $display("FAIL mid_restart_pc_en got=%b exp=0010", r_pc_en[3:0]); end
   endtask

   initial begin
      test_reset();
      test_nop();
      test_alu();
      test_branch();
      test_imm_forms();
      test_memory();
      test_illegal();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
